// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the pipeline hazard/stall controller.
//   hz_state_t  : controller state (RUN, LU_WAIT, HALTED)
//   stage_t     : index of a producing pipeline stage (ID/EX, EX/MEM, MEM/WB)
//   BR_AT_EX / BR_AT_MEM : values of the BR_STAGE parameter of hazard_ctrl
//   regbits_t   : register-select type, same shape as in cpu_types_pkg
//   stage_bubbles() : bubbles needed when a source matches a given stage
//                     and no forwarding exists (used by HAZARD_NO_FWD_EN)
// ---------------------------------------------------------------------------
package hazard_pkg;

    localparam int REGBITS_W = 5;
    typedef logic [REGBITS_W-1:0] regbits_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LU_WAIT = 2'd1,
        HALTED  = 2'd2
    } hz_state_t;

    typedef enum logic [1:0] {
        STG_IDEX  = 2'd0,
        STG_EXMEM = 2'd1,
        STG_MEMWB = 2'd2
    } stage_t;

    // Stage at which control transfers resolve.
    localparam int BR_AT_EX  = 1;
    localparam int BR_AT_MEM = 2;

    // Without forwarding, a producer in ID/EX is three cycles from the
    // register file write, EX/MEM two, MEM/WB one.
    function automatic int unsigned stage_bubbles(input stage_t s);
        case (s)
            STG_IDEX:  stage_bubbles = 3;
            STG_EXMEM: stage_bubbles = 2;
            default:   stage_bubbles = 1;
        endcase
    endfunction

endpackage

// File: rtl/raw_match.sv
// ---------------------------------------------------------------------------
// raw_match
// Read-after-write match for one source select against one destination.
// Register 0 is hard-wired and never produces a hazard.
// Ports:
//   src   : source register select (decode stage)
//   wsel  : destination register select of a later stage
//   valid : that stage will write wsel
//   hit   : hazard on this pair
// ---------------------------------------------------------------------------
module raw_match #(
    parameter int W = 5
) (
    input  logic [W-1:0] src,
    input  logic [W-1:0] wsel,
    input  logic         valid,
    output logic         hit
);

    assign hit = valid && (src == wsel) && (src != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Hazard/stall controller for the 5-stage pipeline. Drives the latch
// enables and bubble-insert flushes from load-use, control-transfer,
// data-memory wait and halt conditions. Sequential behaviour: multi-cycle
// load-use stalls (LU_WAIT), a flush deferred across a memory wait
// (pend_flush) and a sticky HALTED state left only through reset.
//
// Build option: HAZARD_NO_FWD_EN -- no forwarding path, so any RAW match
// against ID/EX, EX/MEM or MEM/WB stalls for 3, 2 or 1 bubbles; the oldest
// matching stage decides the count. Undefined: only load-use stalls.
//
// Ports:
//   CLK, nRST                   : clock, asynchronous active-low reset
//   ihit, dhit                  : instruction fetch / data access complete
//   ifid_rs, ifid_rt            : decode-stage source selects
//   idex/exmem/memwb_wsel       : destination selects
//   idex/exmem/memwb_RegWrite   : destination valid
//   idex_dREN                   : EX-stage instruction is a load
//   exmem_dREN, exmem_dWEN      : MEM-stage memory access
//   xfer_taken                  : branch taken / jump at resolving stage
//   halt                        : halt reached MEM/WB
//   pc_en .. memwb_en           : latch enables
//   ifid/idex/exmem_flush       : bubble insert, applied with the enable
//   stalled                     : pc held this cycle
//   dbg_state                   : current controller state
// ---------------------------------------------------------------------------
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W    = 5,
    parameter int LU_STALL = 1,
    parameter int BR_STAGE = BR_AT_MEM,
    parameter int CNT_W    = 2
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic [REG_W-1:0] idex_wsel,
    input  logic [REG_W-1:0] exmem_wsel,
    input  logic [REG_W-1:0] memwb_wsel,
    input  logic             idex_RegWrite,
    input  logic             exmem_RegWrite,
    input  logic             memwb_RegWrite,
    input  logic             idex_dREN,
    input  logic             exmem_dREN,
    input  logic             exmem_dWEN,
    input  logic             xfer_taken,
    input  logic             halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             stalled,
    output hz_state_t        dbg_state
);

    localparam logic FLUSH_EXMEM = (BR_STAGE == BR_AT_MEM);

    hz_state_t        state, nxt_state;
    logic [CNT_W-1:0] cnt, nxt_cnt;
    logic             pend_flush, nxt_pend;

    // Bit index follows stage_t: 0 = ID/EX, 1 = EX/MEM, 2 = MEM/WB.
    logic [2:0][REG_W-1:0] wsel_v;
    logic [2:0]            valid_v;
    logic [2:0]            hit_rs, hit_rt, hit;

    assign wsel_v  = {memwb_wsel, exmem_wsel, idex_wsel};
    assign valid_v = {memwb_RegWrite, exmem_RegWrite, idex_RegWrite};

    for (genvar s = 0; s < 3; s++) begin : g_stage
        raw_match #(.W(REG_W)) u_rs (
            .src   (ifid_rs),
            .wsel  (wsel_v[s]),
            .valid (valid_v[s]),
            .hit   (hit_rs[s])
        );
        raw_match #(.W(REG_W)) u_rt (
            .src   (ifid_rt),
            .wsel  (wsel_v[s]),
            .valid (valid_v[s]),
            .hit   (hit_rt[s])
        );
    end

    assign hit = hit_rs | hit_rt;

    logic             stall_req;
    logic [CNT_W-1:0] load_cnt;
    logic             unused_raw;

`ifdef HAZARD_NO_FWD_EN
    // Any RAW match stalls; the oldest matching producer sets the length.
    // CNT_W must hold 2 in this build.
    always_comb begin
        stall_req = |hit;
        if (hit[STG_MEMWB])
            load_cnt = CNT_W'(stage_bubbles(STG_MEMWB) - 1);
        else if (hit[STG_EXMEM])
            load_cnt = CNT_W'(stage_bubbles(STG_EXMEM) - 1);
        else
            load_cnt = CNT_W'(stage_bubbles(STG_IDEX) - 1);
    end
    assign unused_raw = ^{idex_dREN, LU_STALL[0]};
`else
    // Forwarding covers everything except a load feeding the next decode.
    assign stall_req  = idex_dREN & hit[STG_IDEX];
    assign load_cnt   = CNT_W'(LU_STALL - 1);
    assign unused_raw = ^hit[2:1];
`endif

    logic mem_wait;
    assign mem_wait = (exmem_dREN | exmem_dWEN) & ~dhit;

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        nxt_state   = state;
        nxt_cnt     = cnt;
        nxt_pend    = pend_flush;

        if (!nRST) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (state == HALTED) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (halt) begin
            // Let the halting instruction retire, freeze everything behind it.
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            idex_en   = 1'b0;
            exmem_en  = 1'b0;
            nxt_state = HALTED;
        end else if (mem_wait) begin
            // MEM/WB keeps moving and receives a bubble from EX/MEM; a
            // control transfer seen now is replayed once the access ends.
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            exmem_flush = 1'b1;
            if (xfer_taken)
                nxt_pend = 1'b1;
        end else if (xfer_taken || pend_flush) begin
            pc_en       = ihit;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = FLUSH_EXMEM;
            nxt_pend    = 1'b0;
            nxt_state   = RUN;
            nxt_cnt     = '0;
        end else if (state == LU_WAIT || stall_req) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            if (state == LU_WAIT) begin
                // cnt holds the bubbles still owed after this one plus one.
                if (cnt <= CNT_W'(1)) begin
                    nxt_state = RUN;
                    nxt_cnt   = '0;
                end else begin
                    nxt_cnt = cnt - CNT_W'(1);
                end
            end else if (load_cnt != '0) begin
                nxt_state = LU_WAIT;
                nxt_cnt   = load_cnt;
            end
        end else if (!ihit) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
        end
    end

    assign stalled   = nRST & ~pc_en;
    assign dbg_state = state;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= RUN;
            cnt        <= '0;
            pend_flush <= 1'b0;
        end else begin
            state      <= nxt_state;
            cnt        <= nxt_cnt;
            pend_flush <= nxt_pend;
        end
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Parametrised hazard/stall controller for the 5-stage pipelined datapath; successor to the combinational hazard unit.
- Sits beside the pipeline latches. Drives per-latch enable/flush from RAW, load-use, control-transfer, cache-wait and halt conditions.
- Adds sequential behaviour: multi-cycle load-use stalls, deferred flush across memory waits, sticky halt.

Parameters:
- REG_W, 5, register-select width (regbits_t).
- LU_STALL, 1, bubble cycles inserted per load-use hazard (1..3).
- BR_STAGE, 2, stage resolving control transfer: 2 = EX/MEM (flush IF/ID, ID/EX, EX/MEM); 1 = ID/EX (flush IF/ID, ID/EX).
- CNT_W, 2, width of the stall counter; must hold LU_STALL.

Ports:
- CLK  in  1  clock
- nRST  in  1  async active-low reset
- ihit  in  1  instruction fetch complete
- dhit  in  1  data access complete
- ifid_rs, ifid_rt  in  REG_W each  decode-stage source selects
- idex_wsel, exmem_wsel, memwb_wsel  in  REG_W each  destination selects
- idex_RegWrite, exmem_RegWrite, memwb_RegWrite  in  1 each  destination valid
- idex_dREN  in  1  EX-stage instruction is a load
- exmem_dREN, exmem_dWEN  in  1 each  MEM-stage memory access
- xfer_taken  in  1  branch taken / jump at resolving stage
- halt  in  1  halt reached MEM/WB
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch enables
- ifid_flush, idex_flush, exmem_flush  out  1 each  bubble insert (synchronous, applied with enable)
- stalled  out  1  any stall this cycle

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-low on nRST. The polarity and synchronicity are fixed.
- While nRST=0: all *_en=0, all *_flush=1, stalled=0. Internal state: state=RUN, cnt=0, pend_flush=0.
- States:
  - RUN
  - LU_WAIT (counting bubbles)
  - HALTED (sticky until reset)
- Outputs are combinational from state, pend_flush, cnt and the inputs. Zero latency.
- Register 0 never produces a hazard.
- Per-cycle priority, highest first:
  1. HALTED: all en=0, all flush=0, stalled=1.
  2. halt=1: go to HALTED next; this cycle memwb_en=1, other en=0.
  3. mem_wait = (exmem_dREN|exmem_dWEN) & !dhit:
     - pc/ifid/idex/exmem en=0, memwb_en=1.
     - No flush, except that exmem enters MEM/WB as a bubble: memwb gets an exmem_flush-equivalent via exmem_flush=1.
     - If xfer_taken=1, set pend_flush=1.
     - cnt is frozen.
  4. xfer_taken=1 or pend_flush=1:
     - All en=1 (pc_en only if ihit).
     - Flush the stages given by BR_STAGE.
     - Clear pend_flush. Abort any LU_WAIT: go to RUN, cnt=0.
  5. Load-use, when idex_dREN & idex_RegWrite & idex_wsel∈{ifid_rs,ifid_rt}, or when in LU_WAIT:
     - pc_en=ifid_en=0, idex_flush=1, idex_en=1.
     - RUN→LU_WAIT with cnt=LU_STALL-1. In LU_WAIT, decrement cnt; go to RUN on cnt==0 that cycle.
     - With LU_STALL=1, LU_WAIT is never entered.
  6. !ihit: pc_en=0, ifid_en=1, ifid_flush=1. Downstream stages proceed.
  7. Otherwise: all en=1, flush=0.
- stalled=1 whenever pc_en=0 and nRST=1.
- Reset mid-stall clears state, cnt and pend_flush immediately.

Optional Feature:
- Macro: HAZARD_NO_FWD_EN.
- When defined, no forwarding unit exists, so full RAW stalls apply. Rule 5 is extended: a stall also occurs if ifid_rs or ifid_rt matches a valid idex_wsel, exmem_wsel or memwb_wsel (the latter is assumed not to have a write-before-read register file). The bubble count is 3, 2 or 1 respectively, loaded into cnt as count-1. The oldest matching stage wins.
- When undefined, only load-use hazards stall (forwarding assumed).

Decomposition:
- Shared package hazard_pkg:
  - hz_state_t enum {RUN, LU_WAIT, HALTED}
  - stage index enum
  - constants BR_AT_EX=1, BR_AT_MEM=2
  - regbits_t reused from cpu_types_pkg.
- Sub-module raw_match: compares one source select against (wsel, valid) and masks register 0. Instantiated once per comparison.

Test Plan:
- Reset: hold nRST=0 for 3 cycles → all en=0, flushes=1. Release with ihit=1 and no hazards → all en=1, flush=0 in the first cycle.
- Load-use: idex_dREN=1, idex_RegWrite=1, idex_wsel=5, ifid_rs=5, LU_STALL=2 → pc_en=ifid_en=0 and idex_flush=1 for exactly 2 cycles, then normal operation. Repeat with ifid_rs=0 and idex_wsel=0 → no stall.
- Branch during memory wait: exmem_dREN=1, dhit=0 for 3 cycles, xfer_taken=1 in cycle 1 only → all front en=0 for 3 cycles. The cycle after dhit: ifid/idex/exmem_flush=1 (BR_STAGE=2).
- Branch aborts load-use: LU_STALL=3, xfer_taken=1 in the 2nd bubble cycle → flush asserted, stall ends, state=RUN.
- Halt: halt=1 → next cycle and onward all en=0, stalled=1, regardless of ihit/dhit, until nRST asserted.
- HAZARD_NO_FWD_EN: exmem_RegWrite=1, exmem_wsel=7, ifid_rt=7 → 2 stall cycles. Without the macro → 0 stall cycles.
